// File: rtl/aes_loader_pkg.sv
// Shared state type and sizing constants for the AES word loader.
package aes_loader_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      RUN    = 2'd2,
      UNLOAD = 2'd3
   } loader_state_e;

   localparam int WORDS_PER_BLK = 4;
   localparam int SLOT_W        = 32;
   localparam int BLK_W         = SLOT_W * WORDS_PER_BLK;
   localparam int TMO_CNT_W     = 8;
   localparam int WORD_CNT_W    = 3;

   // Inbound word indices: 0..3 are key words, 4..7 are data words, MSW first.
   localparam logic [WORD_CNT_W-1:0] KEY_WORD_FIRST  = 3'd0;
   localparam logic [WORD_CNT_W-1:0] KEY_WORD_LAST   = 3'd3;
   localparam logic [WORD_CNT_W-1:0] DATA_WORD_FIRST = 3'd4;
   localparam logic [WORD_CNT_W-1:0] DATA_WORD_LAST  = 3'd7;
   localparam logic [1:0]            LAST_SLOT       = 2'(WORDS_PER_BLK - 1);

endpackage

// File: rtl/aes_word_shreg.sv
// 128-bit register of four 32-bit slots (slot 0 = [127:96]) with per-slot write,
// full parallel load and a one-slot shift toward the MSW end.
module aes_word_shreg
   import aes_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [1:0]        wr_idx,
   input  logic [SLOT_W-1:0] wr_word,
   input  logic              ld_en,
   input  logic [BLK_W-1:0]  ld_val,
   input  logic              shift_en,
   output logic [BLK_W-1:0]  q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (ld_en) begin
         q <= ld_val;
      end else if (shift_en) begin
         q <= {q[BLK_W-SLOT_W-1:0], {SLOT_W{1'b0}}};
      end else if (wr_en) begin
         case (wr_idx)
            2'd0:    q[127:96] <= wr_word;
            2'd1:    q[95:64]  <= wr_word;
            2'd2:    q[63:32]  <= wr_word;
            default: q[31:0]   <= wr_word;
         endcase
      end
   end

endmodule

// File: rtl/aes_word_loader.sv
// Word-stream front end for AES_top: assembles key/data, runs the core, streams the result back.
// Optional build macro AES_KEY_REUSE_EN adds AES_key_keep to reuse the stored key for 4-word blocks.
module aes_word_loader
   import aes_loader_pkg::*;
#(
   parameter int TIMEOUT_CYC = 64,
   parameter int WORD_W      = 32
)(
   input  logic              AES_clk,
   input  logic              AES_rst,
   input  logic [WORD_W-1:0] AES_in_word,
   input  logic              AES_in_valid,
   output logic              AES_in_ready,
   output logic [WORD_W-1:0] AES_out_word,
   output logic              AES_out_valid,
   input  logic              AES_out_ready,
   output logic              AES_err,
   output logic              AES_en,
   output logic [127:0]      AES_key_in,
   output logic [127:0]      AES_data_in,
   input  logic [127:0]      AES_data_out,
   input  logic              AES_data_out_valid
`ifdef AES_KEY_REUSE_EN
   ,
   input  logic              AES_key_keep
`endif
);

   localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYC - 1);

   loader_state_e         state, state_next;
   logic [WORD_CNT_W-1:0] wcnt, wcnt_next;
   logic [TMO_CNT_W-1:0]  tcnt, tcnt_next;
   logic                  en_q, en_next;
   logic                  err_q, err_next;
   logic                  in_ready_q, in_ready_next;
   logic                  out_valid_q, out_valid_next;
   logic                  key_wr, data_wr, res_ld, res_shift;
   logic                  in_xfer, out_xfer, reuse_key;
   logic [1:0]            wr_idx;
   logic [BLK_W-1:0]      key_q, data_q, result_q;

`ifdef AES_KEY_REUSE_EN
   // A key counts as loaded once its last word has been written since reset.
   logic key_loaded;

   always_ff @(posedge AES_clk) begin
      if (AES_rst) begin
         key_loaded <= 1'b0;
      end else if (key_wr && (wr_idx == KEY_WORD_LAST[1:0])) begin
         key_loaded <= 1'b1;
      end
   end

   assign reuse_key = AES_key_keep && key_loaded;
`else
   assign reuse_key = 1'b0;
`endif

   always_ff @(posedge AES_clk) begin
      if (AES_rst) begin
         state       <= IDLE;
         wcnt        <= '0;
         tcnt        <= '0;
         en_q        <= 1'b0;
         err_q       <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state       <= state_next;
         wcnt        <= wcnt_next;
         tcnt        <= tcnt_next;
         en_q        <= en_next;
         err_q       <= err_next;
         in_ready_q  <= in_ready_next;
         out_valid_q <= out_valid_next;
      end
   end

   // Handshake outputs are registered from the next state, so ready never looks at valid.
   always_comb begin
      state_next = state;
      wcnt_next  = wcnt;
      tcnt_next  = tcnt;
      en_next    = 1'b0;
      err_next   = 1'b0;
      key_wr     = 1'b0;
      data_wr    = 1'b0;
      res_ld     = 1'b0;
      res_shift  = 1'b0;
      wr_idx     = wcnt[1:0];
      in_xfer    = AES_in_valid && in_ready_q;
      out_xfer   = out_valid_q && AES_out_ready;

      case (state)
         IDLE: begin
            if (in_xfer) begin
               state_next = LOAD;
               wr_idx     = 2'd0;
               if (reuse_key) begin
                  data_wr   = 1'b1;
                  wcnt_next = DATA_WORD_FIRST + WORD_CNT_W'(1);
               end else begin
                  key_wr    = 1'b1;
                  wcnt_next = KEY_WORD_FIRST + WORD_CNT_W'(1);
               end
            end
         end
         LOAD: begin
            if (in_xfer) begin
               key_wr    = (wcnt <= KEY_WORD_LAST);
               data_wr   = !(wcnt <= KEY_WORD_LAST);
               wcnt_next = wcnt + WORD_CNT_W'(1);
               if (wcnt == DATA_WORD_LAST) begin
                  state_next = RUN;
                  en_next    = 1'b1;
                  wcnt_next  = '0;
                  tcnt_next  = '0;
               end
            end
         end
         RUN: begin
            // Core valid takes priority over a timeout landing on the same edge.
            if (AES_data_out_valid) begin
               res_ld     = 1'b1;
               state_next = UNLOAD;
            end else if (tcnt == TMO_LAST) begin
               err_next   = 1'b1;
               state_next = IDLE;
            end else begin
               tcnt_next = tcnt + TMO_CNT_W'(1);
               en_next   = 1'b1;
            end
         end
         UNLOAD: begin
            if (out_xfer) begin
               res_shift = 1'b1;
               wcnt_next = wcnt + WORD_CNT_W'(1);
               if (wcnt[1:0] == LAST_SLOT) begin
                  state_next = IDLE;
                  wcnt_next  = '0;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      in_ready_next  = (state_next == IDLE) || (state_next == LOAD);
      out_valid_next = (state_next == UNLOAD);
   end

   aes_word_shreg u_key_reg (
      .clk      (AES_clk),
      .rst      (AES_rst),
      .wr_en    (key_wr),
      .wr_idx   (wr_idx),
      .wr_word  (AES_in_word),
      .ld_en    (1'b0),
      .ld_val   ('0),
      .shift_en (1'b0),
      .q        (key_q)
   );

   aes_word_shreg u_data_reg (
      .clk      (AES_clk),
      .rst      (AES_rst),
      .wr_en    (data_wr),
      .wr_idx   (wr_idx),
      .wr_word  (AES_in_word),
      .ld_en    (1'b0),
      .ld_val   ('0),
      .shift_en (1'b0),
      .q        (data_q)
   );

   // The result drains by shifting, so the outgoing word is always the top slot.
   aes_word_shreg u_result_reg (
      .clk      (AES_clk),
      .rst      (AES_rst),
      .wr_en    (1'b0),
      .wr_idx   (2'd0),
      .wr_word  ('0),
      .ld_en    (res_ld),
      .ld_val   (AES_data_out),
      .shift_en (res_shift),
      .q        (result_q)
   );

   assign AES_in_ready  = in_ready_q;
   assign AES_out_valid = out_valid_q;
   assign AES_out_word  = result_q[BLK_W-1 -: SLOT_W];
   assign AES_err       = err_q;
   assign AES_en        = en_q;
   assign AES_key_in    = key_q;
   assign AES_data_in   = data_q;

endmodule

// File: tb/tb_aes_word_loader.sv
// Self-checking bench for aes_word_loader with a behavioural AES-128 core stub.
// Build with AES_KEY_REUSE_EN defined to also exercise key reuse.
module tb_aes_word_loader;

   localparam int TMO = 64;
   localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         AES_clk = 1'b0;
   logic         AES_rst;
   logic [31:0]  AES_in_word;
   logic         AES_in_valid;
   logic         AES_in_ready;
   logic [31:0]  AES_out_word;
   logic         AES_out_valid;
   logic         AES_out_ready;
   logic         AES_err;
   logic         AES_en;
   logic [127:0] AES_key_in;
   logic [127:0] AES_data_in;
   logic [127:0] AES_data_out;
   logic         AES_data_out_valid;
   logic         AES_key_keep;

   logic         stub_valid = 1'b0;
   logic [127:0] stub_data  = '0;
   logic         inj_valid  = 1'b0;
   int           core_lat   = 5;
   bit           core_on    = 1'b1;
   int           core_cnt   = 0;

   int checks = 0;
   int errors = 0;

   logic [7:0] sbox_tab [256];

   always #5 AES_clk = ~AES_clk;

   aes_word_loader #(.TIMEOUT_CYC(TMO), .WORD_W(32)) dut (
      .AES_clk            (AES_clk),
      .AES_rst            (AES_rst),
      .AES_in_word        (AES_in_word),
      .AES_in_valid       (AES_in_valid),
      .AES_in_ready       (AES_in_ready),
      .AES_out_word       (AES_out_word),
      .AES_out_valid      (AES_out_valid),
      .AES_out_ready      (AES_out_ready),
      .AES_err            (AES_err),
      .AES_en             (AES_en),
      .AES_key_in         (AES_key_in),
      .AES_data_in        (AES_data_in),
      .AES_data_out       (AES_data_out),
      .AES_data_out_valid (AES_data_out_valid)
`ifdef AES_KEY_REUSE_EN
      ,
      .AES_key_keep       (AES_key_keep)
`endif
   );

   assign AES_data_out_valid = stub_valid | inj_valid;
   assign AES_data_out       = inj_valid ? {4{32'hdeadbeef}} : stub_data;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // Plain FIPS-197 AES-128 encryption, byte 0 = bits [127:120], column-major state.
   function automatic logic [127:0] aes128(input logic [127:0] key, input logic [127:0] pt);
      logic [31:0]  w [44];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [31:0]  tmp;
      logic [7:0]   rc;
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] ct;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]],
                   sbox_tab[tmp[31:24]]} ^ {rc, 24'h000000};
            rc = xtime(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sbox_tab[s[i]];
         for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) s[rr+4*c] = t[rr+4*((c+rr)%4)];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
               s[4*c+3] = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
      return ct;
   endfunction

   // Core stub: asserts valid for one cycle after core_lat cycles of AES_en.
   always @(posedge AES_clk) begin
      stub_valid <= 1'b0;
      if (AES_en && core_on) begin
         if (core_cnt == core_lat - 1) begin
            stub_valid <= 1'b1;
            stub_data  <= aes128(AES_key_in, AES_data_in);
         end
         core_cnt <= core_cnt + 1;
      end else begin
         core_cnt <= 0;
      end
   end

   task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge AES_clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic [31:0] w, input int gap, input string tag);
      int t;
      repeat (gap) begin
         AES_in_valid = 1'b0;
         tick();
      end
      AES_in_valid = 1'b1;
      AES_in_word  = w;
      t = 0;
      while (AES_in_ready !== 1'b1 && t < 100) begin
         tick();
         t++;
      end
      if (t >= 100) check_output({tag, "_ready_wait"}, 128'(AES_in_ready), 128'd1);
      tick();
      AES_in_valid = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check_output({tag, "_en"},        128'(AES_en),        128'd0);
      check_output({tag, "_err"},       128'(AES_err),       128'd0);
      check_output({tag, "_in_ready"},  128'(AES_in_ready),  128'd0);
      check_output({tag, "_out_valid"}, 128'(AES_out_valid), 128'd0);
      check_output({tag, "_out_word"},  128'(AES_out_word),  128'd0);
      check_output({tag, "_key_in"},    AES_key_in,          128'd0);
      check_output({tag, "_data_in"},   AES_data_in,         128'd0);
   endtask

   task automatic pulse_reset(input string tag);
      AES_rst = 1'b1;
      tick();
      check_all_zero(tag);
      AES_rst      = 1'b0;
      AES_in_valid = 1'b0;
   endtask

   task automatic collect(input logic [127:0] exp, input int stall_word, input string tag);
      int i;
      int t;
      i = 0;
      t = 0;
      AES_out_ready = 1'b1;
      while (i < 4 && t < 2000) begin
         if (AES_out_valid === 1'b1) begin
            check_output($sformatf("%s_w%0d", tag, i), 128'(AES_out_word), 128'(exp[127-32*i -: 32]));
            if (i == stall_word) begin
               AES_out_ready = 1'b0;
               repeat (10) begin
                  tick();
                  t++;
                  check_output($sformatf("%s_stall_w%0d", tag, i), 128'(AES_out_word),
                               128'(exp[127-32*i -: 32]));
                  check_output({tag, "_stall_valid"}, 128'(AES_out_valid), 128'd1);
                  check_output({tag, "_stall_in_ready"}, 128'(AES_in_ready), 128'd0);
               end
               AES_out_ready = 1'b1;
            end
            i++;
         end
         tick();
         t++;
      end
      check_output({tag, "_words_out"}, 128'(i), 128'd4);
      check_output({tag, "_idle_out_valid"}, 128'(AES_out_valid), 128'd0);
      check_output({tag, "_idle_in_ready"}, 128'(AES_in_ready), 128'd1);
   endtask

   task automatic run_block(input logic [127:0] key, input logic [127:0] data,
                            input logic [127:0] exp, input int lat, input int gap,
                            input int stall_word, input bit keep, input bit skip_key,
                            input string tag);
      int  n;
      bit  err_seen;
      int  first;
      core_lat = lat;
      core_on  = 1'b1;
      first    = skip_key ? 4 : 0;
      for (int i = first; i < 8; i++) begin
         AES_key_keep = (i == first) ? keep : 1'b0;
         apply_stimulus((i < 4) ? key[127-32*i -: 32] : data[127-32*(i-4) -: 32], gap, tag);
      end
      AES_key_keep = 1'b0;
      check_output({tag, "_en_rise"},  128'(AES_en), 128'd1);
      check_output({tag, "_key_in"},   AES_key_in,   key);
      check_output({tag, "_data_in"},  AES_data_in,  data);
      n        = 0;
      err_seen = 1'b0;
      while (AES_en === 1'b1 && n < 300) begin
         tick();
         n++;
         if (AES_err === 1'b1) err_seen = 1'b1;
      end
      check_output({tag, "_en_cycles"}, 128'(n), 128'(lat + 1));
      check_output({tag, "_no_err"}, 128'(err_seen), 128'd0);
      check_output({tag, "_first_valid"}, 128'(AES_out_valid), 128'd1);
      collect(exp, stall_word, tag);
      check_output({tag, "_key_persist"}, AES_key_in, key);
   endtask

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      logic [127:0] k, d;
      logic [7:0]   inv, x8;
      int           n;
      bit           seen;

      for (int x = 0; x < 256; x++) begin
         x8  = 8'(x);
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(x8, 8'(y)) == 8'h01) inv = 8'(y);
         sbox_tab[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                       {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end

      AES_rst       = 1'b1;
      AES_in_word   = '0;
      AES_in_valid  = 1'b0;
      AES_out_ready = 1'b1;
      AES_key_keep  = 1'b0;
      repeat (2) tick();
      check_all_zero("reset");
      AES_rst = 1'b0;
      tick();
      check_output("idle_in_ready", 128'(AES_in_ready), 128'd1);

      // FIPS-197 vector with downstream stalled for 10 cycles on word 1.
      run_block(FIPS_KEY, FIPS_PT, FIPS_CT, 5, 0, 1, 1'b0, 1'b0, "fips");

      // Core that never answers: one error pulse TMO cycles after RUN entry.
      k = {$urandom, $urandom, $urandom, $urandom};
      d = {$urandom, $urandom, $urandom, $urandom};
      core_on = 1'b0;
      for (int i = 0; i < 8; i++)
         apply_stimulus((i < 4) ? k[127-32*i -: 32] : d[127-32*(i-4) -: 32], 0, "tmo");
      n    = 0;
      seen = 1'b0;
      while (AES_err !== 1'b1 && n < 300) begin
         tick();
         n++;
         if (AES_out_valid === 1'b1) seen = 1'b1;
      end
      check_output("tmo_cycles", 128'(n), 128'(TMO));
      check_output("tmo_en_low", 128'(AES_en), 128'd0);
      check_output("tmo_in_ready", 128'(AES_in_ready), 128'd1);
      check_output("tmo_no_out", 128'(seen), 128'd0);
      tick();
      check_output("tmo_err_pulse", 128'(AES_err), 128'd0);
      check_output("tmo_ready_after", 128'(AES_in_ready), 128'd1);
      core_on = 1'b1;

      // Valid arriving on the very edge the timeout would fire wins.
      k = {$urandom, $urandom, $urandom, $urandom};
      d = {$urandom, $urandom, $urandom, $urandom};
      run_block(k, d, aes128(k, d), TMO - 1, 0, -1, 1'b0, 1'b0, "tmo_edge");

      // Reset during LOAD word 5, then during RUN; nothing may come out afterwards.
      for (int i = 0; i < 5; i++)
         apply_stimulus((i < 4) ? k[127-32*i -: 32] : d[127-32*(i-4) -: 32], 0, "rst_load");
      AES_in_valid = 1'b1;
      AES_in_word  = d[95:64];
      pulse_reset("rst_load");
      core_lat = 20;
      for (int i = 0; i < 8; i++)
         apply_stimulus((i < 4) ? k[127-32*i -: 32] : d[127-32*(i-4) -: 32], 0, "rst_run");
      tick();
      pulse_reset("rst_run");
      seen = 1'b0;
      repeat (30) begin
         tick();
         if (AES_out_valid === 1'b1 || AES_err === 1'b1 || AES_en === 1'b1) seen = 1'b1;
      end
      check_output("rst_run_quiet", 128'(seen), 128'd0);
      k = {$urandom, $urandom, $urandom, $urandom};
      d = {$urandom, $urandom, $urandom, $urandom};
      run_block(k, d, aes128(k, d), 3, 0, -1, 1'b0, 1'b0, "post_rst");

      // Randomised blocks with random core latency and inbound gaps.
      for (int r = 0; r < 3; r++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         d = {$urandom, $urandom, $urandom, $urandom};
         run_block(k, d, aes128(k, d), $urandom_range(1, 10), $urandom_range(0, 2), -1,
                   1'b0, 1'b0, $sformatf("rnd%0d", r));
      end

      // Same block back-to-back, then a stray core valid in IDLE, then toggled valid.
      k = {$urandom, $urandom, $urandom, $urandom};
      d = {$urandom, $urandom, $urandom, $urandom};
      run_block(k, d, aes128(k, d), 4, 0, -1, 1'b0, 1'b0, "b2b");
      inj_valid = 1'b1;
      tick();
      inj_valid = 1'b0;
      check_output("idle_inj_out_valid", 128'(AES_out_valid), 128'd0);
      check_output("idle_inj_en", 128'(AES_en), 128'd0);
      check_output("idle_inj_in_ready", 128'(AES_in_ready), 128'd1);
      tick();
      check_output("idle_inj_out_valid2", 128'(AES_out_valid), 128'd0);
      run_block(k, d, aes128(k, d), 4, 1, -1, 1'b0, 1'b0, "toggle");

`ifdef AES_KEY_REUSE_EN
      // Keep with no key since reset acts as a normal 8-word block, then reuse the key.
      pulse_reset("reuse_rst");
      tick();
      run_block(FIPS_KEY, FIPS_PT, FIPS_CT, 3, 0, -1, 1'b1, 1'b0, "keep_nokey");
      run_block(FIPS_KEY, FIPS_PT, FIPS_CT, 4, 0, -1, 1'b1, 1'b1, "reuse_fips");
      d = {$urandom, $urandom, $urandom, $urandom};
      run_block(FIPS_KEY, d, aes128(FIPS_KEY, d), 2, 1, -1, 1'b1, 1'b1, "reuse_rnd");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
